register_file: RTL and testbench

- 32-entry general-purpose register file for the MIPS datapath.
- Sits directly downstream of the write-back 2x1 mux: the MemtoReg mux output feeds RF_WriteData, and the RegDst mux output feeds RF_WriteAddr.
- Two combinational read ports feed the ALU-source mux and the data memory. One synchronous write port.
- Register 0 is hardwired to zero.

---
 rtl/register_file_if.sv | 37 +++
 rtl/register_file.sv | 60 ++++++
 tb/tb_register_file.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/register_file_if.sv
// Bus bundle for the 32-entry MIPS register file: one write port, two read ports
// and the committed-write counter.
interface register_file_if #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  RF_WriteEnable;
  logic [ADDR_WIDTH-1:0] RF_WriteAddr;
  logic [WIDTH-1:0]      RF_WriteData;
  logic [ADDR_WIDTH-1:0] RF_ReadAddr1;
  logic [ADDR_WIDTH-1:0] RF_ReadAddr2;
  logic [WIDTH-1:0]      RF_ReadData1;
  logic [WIDTH-1:0]      RF_ReadData2;
  logic [15:0]           RF_WriteCount;

  modport master (
    output RF_WriteEnable,
    output RF_WriteAddr,
    output RF_WriteData,
    output RF_ReadAddr1,
    output RF_ReadAddr2,
    input  RF_ReadData1,
    input  RF_ReadData2,
    input  RF_WriteCount
  );

  modport slave (
    input  RF_WriteEnable,
    input  RF_WriteAddr,
    input  RF_WriteData,
    input  RF_ReadAddr1,
    input  RF_ReadAddr2,
    output RF_ReadData1,
    output RF_ReadData2,
    output RF_WriteCount
  );
endinterface

// File: rtl/register_file.sv
// 32-entry register file with r0 hardwired to zero, async active-high clear and a write counter.
// Optional macro RF_BYPASS_EN forwards same-cycle write data onto matching read ports.
module register_file #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input logic            CLK,
  input logic            RST,
  register_file_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  // Flop array rather than RAM so the asynchronous clear reaches every entry.
  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [15:0]      count_q;
  logic             write_commit;

  assign write_commit = bus.RF_WriteEnable && (bus.RF_WriteAddr != '0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      count_q <= '0;
    end else if (write_commit) begin
      regs_q[bus.RF_WriteAddr] <= bus.RF_WriteData;
      count_q                  <= count_q + 16'd1;
    end
  end

  logic [WIDTH-1:0] stored1;
  logic [WIDTH-1:0] stored2;

  always_comb begin
    stored1 = '0;
    stored2 = '0;
    if (bus.RF_ReadAddr1 != '0) stored1 = regs_q[bus.RF_ReadAddr1];
    if (bus.RF_ReadAddr2 != '0) stored2 = regs_q[bus.RF_ReadAddr2];
  end

`ifdef RF_BYPASS_EN
  logic bypass_ok;
  assign bypass_ok = !RST && write_commit;

  always_comb begin
    bus.RF_ReadData1 = stored1;
    bus.RF_ReadData2 = stored2;
    if (bypass_ok && (bus.RF_ReadAddr1 == bus.RF_WriteAddr)) bus.RF_ReadData1 = bus.RF_WriteData;
    if (bypass_ok && (bus.RF_ReadAddr2 == bus.RF_WriteAddr)) bus.RF_ReadData2 = bus.RF_WriteData;
  end
`else
  always_comb begin
    bus.RF_ReadData1 = stored1;
    bus.RF_ReadData2 = stored2;
  end
`endif

  assign bus.RF_WriteCount = count_q;
endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file using immediate assertions.
module tb_register_file;
  logic CLK;
  logic RST;
  int   checks;
  int   errors;

  register_file_if #(.WIDTH(32), .ADDR_WIDTH(5)) bus ();

  register_file #(.WIDTH(32), .ADDR_WIDTH(5)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a write, clock one edge, then drop enable 1 time unit after the edge.
  task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
    bus.RF_WriteEnable = 1'b1;
    bus.RF_WriteAddr   = addr;
    bus.RF_WriteData   = data;
    @(posedge CLK);
    #1;
    bus.RF_WriteEnable = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RST = 1'b1;
    bus.RF_WriteEnable = 1'b0;
    bus.RF_WriteAddr   = '0;
    bus.RF_WriteData   = '0;
    bus.RF_ReadAddr1   = '0;
    bus.RF_ReadAddr2   = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_count", {16'h0, bus.RF_WriteCount}, 32'h0);
    bus.RF_ReadAddr1 = 5'd5;
    #1;
    check("reset_r5", bus.RF_ReadData1, 32'h0);
    RST = 1'b0;
    #1;

    // Reset mid-operation
    write_reg(5'd5, 32'hDEADBEEF);
    check("r5_written", bus.RF_ReadData1, 32'hDEADBEEF);
    check("count_after_r5", {16'h0, bus.RF_WriteCount}, 32'h1);
    #2;
    RST = 1'b1;
    #1;
    check("async_clear_r5", bus.RF_ReadData1, 32'h0);
    check("async_clear_count", {16'h0, bus.RF_WriteCount}, 32'h0);
    // Writes are blocked while reset is held across an edge
    bus.RF_WriteEnable = 1'b1;
    bus.RF_WriteAddr   = 5'd5;
    bus.RF_WriteData   = 32'h11111111;
    @(posedge CLK);
    #1;
    bus.RF_WriteEnable = 1'b0;
    check("reset_blocks_write", bus.RF_ReadData1, 32'h0);
    check("reset_holds_count", {16'h0, bus.RF_WriteCount}, 32'h0);
    #1;
    RST = 1'b0;
    #1;

    // Basic write/read, first edge after release
    write_reg(5'd8, 32'h12345678);
    bus.RF_ReadAddr1 = 5'd8;
    bus.RF_ReadAddr2 = 5'd8;
    #1;
    check("basic_rd1", bus.RF_ReadData1, 32'h12345678);
    check("basic_rd2", bus.RF_ReadData2, 32'h12345678);
    check("basic_count", {16'h0, bus.RF_WriteCount}, 32'h1);

    // Register 0 protection
    write_reg(5'd0, 32'hFFFFFFFF);
    bus.RF_ReadAddr1 = 5'd0;
    #1;
    check("r0_zero", bus.RF_ReadData1, 32'h0);
    check("r0_not_counted", {16'h0, bus.RF_WriteCount}, 32'h1);

    // Write-enable low
    bus.RF_WriteEnable = 1'b0;
    bus.RF_WriteAddr   = 5'd3;
    bus.RF_WriteData   = 32'hA5A5A5A5;
    repeat (4) @(posedge CLK);
    #1;
    bus.RF_ReadAddr2 = 5'd3;
    #1;
    check("we_low_r3", bus.RF_ReadData2, 32'h0);
    check("we_low_count", {16'h0, bus.RF_WriteCount}, 32'h1);

    // Same-address read during write
    write_reg(5'd9, 32'h1);
    bus.RF_ReadAddr1   = 5'd9;
    bus.RF_WriteEnable = 1'b1;
    bus.RF_WriteAddr   = 5'd9;
    bus.RF_WriteData   = 32'h2;
    #1;
`ifdef RF_BYPASS_EN
    check("same_addr_before", bus.RF_ReadData1, 32'h2);
`else
    check("same_addr_before", bus.RF_ReadData1, 32'h1);
`endif
    @(posedge CLK);
    #1;
    bus.RF_WriteEnable = 1'b0;
    #1;
    check("same_addr_after", bus.RF_ReadData1, 32'h2);
    check("same_addr_count", {16'h0, bus.RF_WriteCount}, 32'h3);

    // Full sweep r1..r31
    for (int i = 1; i < 32; i++) begin
      write_reg(5'(i), 32'(i) * 32'h01010101);
    end
    for (int i = 0; i < 32; i++) begin
      bus.RF_ReadAddr1 = 5'(i);
      bus.RF_ReadAddr2 = 5'(31 - i);
      #1;
      check("sweep_rd1", bus.RF_ReadData1, 32'(i) * 32'h01010101);
      check("sweep_rd2", bus.RF_ReadData2, 32'(31 - i) * 32'h01010101);
    end
    check("sweep_count", {16'h0, bus.RF_WriteCount}, 32'd34);

    // Counter wrap: 34 counted so far, 65536 total returns to zero
    bus.RF_WriteEnable = 1'b1;
    bus.RF_WriteAddr   = 5'd1;
    bus.RF_WriteData   = 32'hCAFEF00D;
    repeat (65535 - 34) @(posedge CLK);
    #1;
    check("count_ffff", {16'h0, bus.RF_WriteCount}, 32'h0000FFFF);
    @(posedge CLK);
    #1;
    bus.RF_WriteEnable = 1'b0;
    check("count_wrap", {16'h0, bus.RF_WriteCount}, 32'h0);
    bus.RF_ReadAddr1 = 5'd1;
    #1;
    check("wrap_r1", bus.RF_ReadData1, 32'hCAFEF00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
